zeroheti_obi_demux: RTL and testbench



---
 rtl/zeroheti_pkg.sv | 19 +
 rtl/zeroheti_idx_fifo.sv | 65 ++++++
 rtl/zeroheti_obi_demux.sv | 147 ++++++++++++++
 tb/tb_zeroheti_obi_demux.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared zeroHETI fabric types: address-map rule layout and the decode-error
// data pattern returned for unmapped accesses.
package zeroheti_pkg;

    localparam int unsigned RuleAddrWidth  = 32;
    localparam logic [31:0] ErrDataDefault = 32'hBADCAB1E;

    // Both bounds are inclusive; idx names the subordinate port
    typedef struct packed {
        logic [31:0]              idx;
        logic [RuleAddrWidth-1:0] start_addr;
        logic [RuleAddrWidth-1:0] end_addr;
    } addr_map_rule_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zeroheti_idx_fifo.sv
// Small FIFO of target indices, also exposing the most recently pushed value.
// Latency: head visible the cycle after push; no same-cycle bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module zeroheti_idx_fifo
    import zeroheti_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] data,
    output logic [Width-1:0] head,
    output logic [Width-1:0] last,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = clog2_min1(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                last   <= data;
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/zeroheti_obi_demux.sv
// Address-decoding OBI demux, one manager to NumMgrPorts subordinates plus an error subordinate.
// Latency: request/grant and real responses combinational; decode-error response 1 cycle after grant.
// Backpressure: grant held low while tracking FIFO is full or a target switch waits for drain.
module zeroheti_obi_demux
    import zeroheti_pkg::*;
#(
    parameter int unsigned          NumMgrPorts = 6,
    parameter int unsigned          NumRules    = 6,
    parameter int unsigned          MaxTrans    = 4,
    parameter int unsigned          AddrWidth   = 32,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] ErrData     = DataWidth'(ErrDataDefault)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  addr_map_rule_t           addr_map_i [NumRules],

    input  logic                     sbr_req_i,
    output logic                     sbr_gnt_o,
    input  logic [AddrWidth-1:0]     sbr_addr_i,
    input  logic                     sbr_we_i,
    input  logic [DataWidth/8-1:0]   sbr_be_i,
    input  logic [DataWidth-1:0]     sbr_wdata_i,
    output logic                     sbr_rvalid_o,
    output logic [DataWidth-1:0]     sbr_rdata_o,
    output logic                     sbr_err_o,

    output logic [NumMgrPorts-1:0]   mgr_req_o,
    input  logic [NumMgrPorts-1:0]   mgr_gnt_i,
    output logic [AddrWidth-1:0]     mgr_addr_o,
    output logic                     mgr_we_o,
    output logic [DataWidth/8-1:0]   mgr_be_o,
    output logic [DataWidth-1:0]     mgr_wdata_o,
    input  logic [NumMgrPorts-1:0]   mgr_rvalid_i,
    input  logic [DataWidth-1:0]     mgr_rdata_i [NumMgrPorts],
    input  logic [NumMgrPorts-1:0]   mgr_err_i
);

    localparam int unsigned    TgtW    = $clog2(NumMgrPorts + 1);
    localparam int unsigned    ErrCntW = $clog2(MaxTrans + 1);
    localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumMgrPorts);

    logic [RuleAddrWidth-1:0] addr_ext;
    logic [TgtW-1:0]          tgt;
    logic                     is_err;
    logic                     ok;
    logic                     port_gnt;
    logic                     push;
    logic                     err_rsp;
    logic [TgtW-1:0]          head;
    logic [TgtW-1:0]          last;
    logic                     full;
    logic                     empty;
    logic [ErrCntW-1:0]       err_cnt;
    logic [NumMgrPorts-1:0]   spurious;

    assign addr_ext = RuleAddrWidth'(sbr_addr_i);

    // Scan from the highest rule down so the lowest matching rule overwrites last
    always_comb begin
        tgt = ErrTgt;
        for (int r = NumRules - 1; r >= 0; r--) begin
            if ((addr_ext >= addr_map_i[r].start_addr) && (addr_ext <= addr_map_i[r].end_addr)) begin
                tgt = (addr_map_i[r].idx < 32'(NumMgrPorts)) ? TgtW'(addr_map_i[r].idx) : ErrTgt;
            end
        end
    end

    assign is_err = (tgt == ErrTgt);
    // Only one target may be in flight at a time, which keeps responses in order
    assign ok     = ~rst_i & ~full & (empty | (tgt == last));

    always_comb begin
        mgr_req_o = '0;
        port_gnt  = 1'b0;
        for (int p = 0; p < NumMgrPorts; p++) begin
            if (tgt == TgtW'(p)) begin
                mgr_req_o[p] = sbr_req_i & ok;
                port_gnt     = mgr_gnt_i[p];
            end
        end
        sbr_gnt_o = ok & (is_err ? sbr_req_i : port_gnt);
    end

    assign push        = sbr_req_i & sbr_gnt_o;
    assign mgr_addr_o  = sbr_addr_i;
    assign mgr_we_o    = sbr_we_i;
    assign mgr_be_o    = sbr_be_i;
    assign mgr_wdata_o = sbr_wdata_i;

    zeroheti_idx_fifo #(
        .Depth (MaxTrans),
        .Width (TgtW)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (sbr_rvalid_o),
        .data  (tgt),
        .head  (head),
        .last  (last),
        .full  (full),
        .empty (empty)
    );

    assign err_rsp = ~rst_i & ~empty & (head == ErrTgt) & (err_cnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt + ErrCntW'(push & is_err) - ErrCntW'(err_rsp);
        end
    end

    // Outputs are forced to zero when no response is presented
    always_comb begin
        sbr_rvalid_o = 1'b0;
        sbr_rdata_o  = '0;
        sbr_err_o    = 1'b0;
        if (err_rsp) begin
            sbr_rvalid_o = 1'b1;
            sbr_rdata_o  = ErrData;
            sbr_err_o    = 1'b1;
        end else if (~rst_i & ~empty) begin
            for (int p = 0; p < NumMgrPorts; p++) begin
                if ((head == TgtW'(p)) && mgr_rvalid_i[p]) begin
                    sbr_rvalid_o = 1'b1;
                    sbr_rdata_o  = mgr_rdata_i[p];
                    sbr_err_o    = mgr_err_i[p];
                end
            end
        end
    end

    always_comb begin
        spurious = '0;
        for (int p = 0; p < NumMgrPorts; p++) begin
            spurious[p] = mgr_rvalid_i[p] & (empty | (head != TgtW'(p)));
        end
    end

    // A response from a port that is not the FIFO head is dropped, never forwarded
    assert property (@(posedge clk_i) disable iff (rst_i) spurious == '0)
        else $warning("zeroheti_obi_demux: dropped unexpected rvalid 0x%0h", spurious);

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// Directed and randomized bench for zeroheti_obi_demux against an in-order transaction model.
module tb_zeroheti_obi_demux;
    import zeroheti_pkg::*;

    localparam int N  = 6;
    localparam int R  = 6;
    localparam int MT = 4;
    localparam logic [31:0] ERRD = 32'hBADCAB1E;

    typedef struct { int unsigned due; logic [31:0] dat; logic err; int port; } sub_t;
    typedef struct { logic [31:0] dat; logic err; } rsp_t;
    typedef struct { logic [31:0] addr; logic we; } req_t;

    logic           clk;
    logic           rst;
    addr_map_rule_t addr_map [R];
    logic           sbr_req, sbr_gnt, sbr_we, sbr_rvalid, sbr_err;
    logic [31:0]    sbr_addr, sbr_wdata, sbr_rdata;
    logic [3:0]     sbr_be;
    logic [N-1:0]   mgr_req, mgr_gnt, mgr_rvalid, mgr_err;
    logic [31:0]    mgr_addr, mgr_wdata;
    logic           mgr_we;
    logic [3:0]     mgr_be;
    logic [31:0]    mgr_rdata [N];

    zeroheti_obi_demux #(
        .NumMgrPorts (N), .NumRules (R), .MaxTrans (MT),
        .AddrWidth (32), .DataWidth (32), .ErrData (ERRD)
    ) dut (
        .clk_i (clk), .rst_i (rst), .addr_map_i (addr_map),
        .sbr_req_i (sbr_req), .sbr_gnt_o (sbr_gnt), .sbr_addr_i (sbr_addr),
        .sbr_we_i (sbr_we), .sbr_be_i (sbr_be), .sbr_wdata_i (sbr_wdata),
        .sbr_rvalid_o (sbr_rvalid), .sbr_rdata_o (sbr_rdata), .sbr_err_o (sbr_err),
        .mgr_req_o (mgr_req), .mgr_gnt_i (mgr_gnt), .mgr_addr_o (mgr_addr),
        .mgr_we_o (mgr_we), .mgr_be_o (mgr_be), .mgr_wdata_o (mgr_wdata),
        .mgr_rvalid_i (mgr_rvalid), .mgr_rdata_i (mgr_rdata), .mgr_err_i (mgr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sub_t        sub_q [$];
    rsp_t        exp_q [$];
    int          tq [$];
    int unsigned err_due [$];
    req_t        pend_q [$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          lat [N];
    int          gnt_prob = 100;
    int          req_prob = 0;
    bit          rand_en = 0;

    logic [N-1:0] obs_req_last, obs_req_or;
    logic [31:0]  last_rdata;
    int           n_rsp, n_err_rsp, gnts_before_rv;
    bit           seen_rv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_obs();
        obs_req_last = '0; obs_req_or = '0; last_rdata = '0;
        n_rsp = 0; n_err_rsp = 0; gnts_before_rv = 0; seen_rv = 0;
    endtask

    // First matching rule wins; no match or out-of-range idx means the error target N
    function automatic int model_decode(input logic [31:0] a);
        for (int r = 0; r < R; r++) begin
            if (a >= addr_map[r].start_addr && a <= addr_map[r].end_addr)
                return (addr_map[r].idx < 32'(N)) ? int'(addr_map[r].idx) : N;
        end
        return N;
    endfunction

    function automatic logic [31:0] port_data(input logic [31:0] a, input int p);
        return a ^ (32'(p + 1) * 32'h01010101);
    endfunction

    task automatic drive(input bit hs);
        logic [31:0] base [7];
        int k;
        base = '{32'h0000_0000, 32'h1000_0000, 32'h3000_0000, 32'h2000_0000,
                 32'h4000_0000, 32'h5000_0000, 32'h9000_0000};
        for (int p = 0; p < N; p++) begin
            mgr_rvalid[p] = 1'b0;
            mgr_rdata[p]  = 32'hDEAD_0000 | 32'(p);
            mgr_err[p]    = 1'($urandom);
            mgr_gnt[p]    = ($urandom_range(0, 99) < gnt_prob);
            for (int i = 0; i < sub_q.size(); i++) begin
                if (sub_q[i].port == p) begin
                    if (sub_q[i].due <= cyc) begin
                        mgr_rvalid[p] = 1'b1;
                        mgr_rdata[p]  = sub_q[i].dat;
                        mgr_err[p]    = sub_q[i].err;
                        sub_q.delete(i);
                    end
                    break;
                end
            end
        end
        if (!sbr_req || hs) begin
            if (pend_q.size() > 0) begin
                req_t rq;
                rq = pend_q.pop_front();
                sbr_req = 1'b1; sbr_addr = rq.addr; sbr_we = rq.we;
                sbr_be = 4'($urandom); sbr_wdata = $urandom;
            end else if (rand_en && $urandom_range(0, 99) < req_prob) begin
                k = $urandom_range(0, 6);
                sbr_req = 1'b1; sbr_addr = base[k] + ($urandom_range(0, 255) << 2);
                sbr_we = 1'($urandom); sbr_be = 4'($urandom); sbr_wdata = $urandom;
            end else begin
                sbr_req = 1'b0;
            end
        end
    endtask

    task automatic step(input bit idle_chk);
        int tgt, head;
        bit ok, e_gnt, e_rv, err_now, hs_model, hs_dut;
        logic [N-1:0] e_req, acc;
        logic [31:0] a_cap;
        @(negedge clk);
        tgt     = model_decode(sbr_addr);
        ok      = !rst && tq.size() < MT && (tq.size() == 0 || tgt == tq[$]);
        e_gnt   = ok && (tgt == N ? sbr_req : mgr_gnt[tgt]);
        e_req   = '0;
        if (ok && sbr_req && tgt < N) e_req[tgt] = 1'b1;
        err_now = err_due.size() > 0 && err_due[0] <= cyc;
        head    = (tq.size() > 0) ? tq[0] : -1;
        e_rv    = !rst && head >= 0 && (head == N ? err_now : mgr_rvalid[head]);
        chk("gnt", sbr_gnt, e_gnt);
        chk("mgr_req", mgr_req, e_req);
        chk("rvalid", sbr_rvalid, e_rv);
        chk("bcast", {mgr_we, mgr_be, mgr_addr}, {sbr_we, sbr_be, sbr_addr});
        if (e_rv && sbr_rvalid) begin
            chk("rdata", sbr_rdata, exp_q[0].dat);
            chk("rerr", sbr_err, exp_q[0].err);
        end
        if (idle_chk) begin
            chk("idle_gnt", sbr_gnt, 0);
            chk("idle_rvalid", sbr_rvalid, 0);
            chk("idle_rdata", sbr_rdata, 0);
            chk("idle_err", sbr_err, 0);
            chk("idle_req", mgr_req, 0);
        end
        hs_dut = sbr_req && sbr_gnt;
        obs_req_or |= mgr_req;
        if (hs_dut) begin
            obs_req_last = mgr_req;
            if (!seen_rv) gnts_before_rv++;
        end
        if (sbr_rvalid) begin
            seen_rv = 1; n_rsp++; last_rdata = sbr_rdata;
            if (sbr_err) n_err_rsp++;
        end
        hs_model = sbr_req && e_gnt;
        acc   = mgr_req & mgr_gnt;
        a_cap = sbr_addr;
        @(posedge clk);
        for (int p = 0; p < N; p++)
            if (acc[p]) sub_q.push_back('{due: cyc + 32'(lat[p]), dat: port_data(a_cap, p), err: a_cap[3], port: p});
        if (rst) begin
            tq.delete(); exp_q.delete(); err_due.delete();
        end else begin
            if (e_rv) begin
                void'(tq.pop_front());
                void'(exp_q.pop_front());
                if (head == N) void'(err_due.pop_front());
            end
            if (hs_model) begin
                tq.push_back(tgt);
                if (tgt == N) begin
                    exp_q.push_back('{dat: ERRD, err: 1'b1});
                    err_due.push_back(cyc + 1);
                end else begin
                    exp_q.push_back('{dat: port_data(a_cap, tgt), err: a_cap[3]});
                end
            end
        end
        cyc++;
        #1;
        drive(hs_dut);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (tq.size() > 0 || sbr_req || pend_q.size() > 0); i++) step(0);
        chk("drain", 64'(tq.size()) + 64'(sbr_req) + 64'(pend_q.size()), 0);
    endtask

    initial begin
        rst = 1'b1; sbr_req = 0; sbr_addr = 0; sbr_we = 0; sbr_be = 0; sbr_wdata = 0;
        mgr_gnt = '0; mgr_rvalid = '0; mgr_err = '0;
        for (int p = 0; p < N; p++) begin mgr_rdata[p] = '0; lat[p] = 1; end
        addr_map[0] = '{idx: 4, start_addr: 32'h3000_0000, end_addr: 32'h3000_FFFF};
        addr_map[1] = '{idx: 1, start_addr: 32'h0000_0000, end_addr: 32'h0000_FFFF};
        addr_map[2] = '{idx: 1, start_addr: 32'h2000_0000, end_addr: 32'h3FFF_FFFF};
        addr_map[3] = '{idx: 2, start_addr: 32'h1000_0000, end_addr: 32'h1000_FFFF};
        addr_map[4] = '{idx: 7, start_addr: 32'h5000_0000, end_addr: 32'h5000_FFFF};
        addr_map[5] = '{idx: 0, start_addr: 32'h4000_0000, end_addr: 32'h4000_FFFF};
        clear_obs();
        gnt_prob = 0;
        step(1); step(1);
        rst = 1'b0;
        step(1);
        gnt_prob = 100;

        // imem read, latency 1
        clear_obs();
        pend_q.push_back('{addr: 32'h100, we: 0});
        drain(20);
        chk("t1_req", obs_req_last, 6'b000010);
        chk("t1_rdata", last_rdata, 32'h0202_0302);

        // unmapped read then write
        clear_obs();
        pend_q.push_back('{addr: 32'h9000_0000, we: 0});
        pend_q.push_back('{addr: 32'h9000_0000, we: 1});
        drain(20);
        chk("t2_err_rsp", n_err_rsp, 2);
        chk("t2_req_or", obs_req_or, 0);
        chk("t2_rdata", last_rdata, ERRD);

        // six reads against a slow target fill the tracker
        clear_obs();
        lat[1] = 5;
        for (int i = 0; i < 6; i++) pend_q.push_back('{addr: 32'(i * 4), we: 0});
        drain(80);
        chk("t3_gnts_before_rsp", gnts_before_rv, MT);
        chk("t3_rsp", n_rsp, 6);

        // alternating targets drain between switches
        clear_obs();
        lat[1] = 3; lat[2] = 3;
        pend_q.push_back('{addr: 32'h200, we: 0});
        pend_q.push_back('{addr: 32'h1000_0000, we: 0});
        pend_q.push_back('{addr: 32'h204, we: 1});
        pend_q.push_back('{addr: 32'h1000_0008, we: 0});
        drain(60);
        chk("t4_rsp", n_rsp, 4);

        // reset with three reads outstanding; stale responses must be dropped
        lat[1] = 6;
        for (int i = 0; i < 3; i++) pend_q.push_back('{addr: 32'h400 + 32'(i * 4), we: 0});
        repeat (6) step(0);
        chk("t5_outstanding", tq.size(), 3);
        gnt_prob = 0;
        step(0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        clear_obs();
        step(1);
        repeat (10) step(0);
        chk("t5_stale_dropped", n_rsp, 0);
        gnt_prob = 100;
        pend_q.push_back('{addr: 32'h300, we: 0});
        drain(30);
        chk("t5_new_rdata", last_rdata, 32'h0202_0102);

        // overlapping rules: lowest rule index wins
        clear_obs();
        pend_q.push_back('{addr: 32'h3000_0010, we: 0});
        drain(20);
        chk("t6_req", obs_req_last, 6'b010000);

        // randomized traffic
        for (int p = 0; p < N; p++) lat[p] = $urandom_range(1, 4);
        gnt_prob = 70; req_prob = 70; rand_en = 1;
        repeat (400) step(0);
        rand_en = 0; gnt_prob = 100;
        drain(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
